// File: rtl/seq_mul_ct.sv
`default_nettype none
// ============================================================================
// Module  : seq_mul_ct
// Brief   : Iterative shift-and-add multiplier, signed/unsigned operands,
//           constant-time (latency WIDTH) or early-termination per operation.
// Rev     : 1.0  initial release
// ============================================================================
module seq_mul_ct #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               const_time,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_o;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic                 r_ct;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_term;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;
  logic                 w_accept;

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign w_a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign w_term = r_b[0] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
  assign w_sum  = r_acc + w_term;
  assign w_last = (r_cnt == C_LAST) ||
                  (!r_ct && ((r_a == '0) || ((r_b >> 1) == '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_ct  <= 1'b0;
      r_o   <= '0;
    end else if (w_accept) begin
      r_a   <= w_a_mag;
      r_b   <= w_b_mag;
      r_neg <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_ct  <= const_time;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_sum;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_o <= r_neg ? -w_sum : w_sum;
    end
  end

  assign o = r_o;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_ct.sv
`default_nettype none
// Self-checking bench for seq_mul_ct (WIDTH=4): transaction-level model with a
// per-cycle compare process, directed literal cases, exhaustive and random runs.
module tb_seq_mul_ct;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   a, b, a_twin;
  logic           signed_mode, const_time;
  logic [2*W-1:0] o, o_twin;
  logic           in_ready_twin, out_valid_twin, busy_twin;
  logic           twin_clr, rst_twin, twin_en, chk_en;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign a_twin   = ~a;
  assign rst_twin = rst | twin_clr;

  seq_mul_ct #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .const_time(const_time),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .busy(busy)
  );

  // Second copy: same b and controls, different a
  seq_mul_ct #(.WIDTH(W)) u_twin (
    .clk(clk), .rst(rst_twin), .in_valid(in_valid), .in_ready(in_ready_twin),
    .a(a_twin), .b(b), .signed_mode(signed_mode), .const_time(const_time),
    .out_valid(out_valid_twin), .out_ready(out_ready), .o(o_twin), .busy(busy_twin)
  );

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
    int p;
    if (sm) p = int'($signed(x)) * int'($signed(y));
    else    p = int'(x) * int'(y);
    return p[2*W-1:0];
  endfunction

  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sm, input logic ct);
    int mx, my, h;
    if (ct) return W;
    mx = (sm && x[W-1]) ? (1 << W) - int'(x) : int'(x);
    my = (sm && y[W-1]) ? (1 << W) - int'(y) : int'(y);
    if (mx == 0 || my == 0) return 1;
    h = 0;
    for (int i = 0; i < W; i++) if (my[i]) h = i;
    return h + 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted op is busy for ref_lat edges, then
  // presents its product until the consumer takes it.
  logic           m_running, m_valid;
  int             m_left;
  logic [2*W-1:0] m_prod, m_o;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_running <= 1'b0;
      m_valid   <= 1'b0;
      m_left    <= 0;
      m_prod    <= '0;
      m_o       <= '0;
    end else if (!m_running && !m_valid) begin
      if (in_valid) begin
        m_running <= 1'b1;
        m_left    <= ref_lat(a, b, signed_mode, const_time);
        m_prod    <= ref_prod(a, b, signed_mode);
      end
    end else if (m_running) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_running <= 1'b0;
        m_valid   <= 1'b1;
        m_o       <= m_prod;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready",  int'(in_ready),  int'(!m_running && !m_valid));
      check("out_valid", int'(out_valid), int'(m_valid));
      check("busy",      int'(busy),      int'(m_running || m_valid));
      check("o",         int'(o),         int'(m_o));
      if (twin_en) check("twin_out_valid", int'(out_valid_twin), int'(out_valid));
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic sm,
                        input logic ct, input int hold,
                        output logic [2*W-1:0] got_o, output int got_lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    a = ta; b = tb_; signed_mode = sm; const_time = ct;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    signed_mode = 1'($urandom); const_time = 1'($urandom);
    got_lat = 0;
    while (!out_valid && got_lat < 40) begin
      @(negedge clk);
      got_lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    got_o = o;
    if (hold > 0) begin
      repeat (hold) begin
        in_valid = 1'($urandom);
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("in_ready_after_hs", int'(in_ready), 1);
      out_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [W-1:0]   x, y;
    logic           sm, ct;
    logic [2*W-1:0] eo;
    int             el;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2*W-1:0] go;
    int             gl;
    logic [7:0]     pair;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; const_time = 1'b0;
    twin_clr = 1'b0; twin_en = 1'b0; chk_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_o",         int'(o),         0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_busy",      int'(busy),      0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Hand-computed expectations
    vecs.push_back('{4'd13, 4'd11, 1'b0, 1'b1, 8'd143,  4});
    vecs.push_back('{4'd5,  4'd1,  1'b0, 1'b0, 8'd5,    1});
    vecs.push_back('{4'd5,  4'd0,  1'b0, 1'b0, 8'd0,    1});
    vecs.push_back('{4'd3,  4'd4,  1'b0, 1'b0, 8'd12,   3});
    vecs.push_back('{4'd0,  4'd15, 1'b0, 1'b0, 8'd0,    1});
    vecs.push_back('{4'd5,  4'd0,  1'b0, 1'b1, 8'd0,    4});
    vecs.push_back('{4'd8,  4'd8,  1'b1, 1'b1, 8'h40,   4});
    vecs.push_back('{4'd13, 4'd5,  1'b1, 1'b1, 8'hF1,   4});
    vecs.push_back('{4'd7,  4'd15, 1'b1, 1'b1, 8'hF9,   4});
    vecs.push_back('{4'd7,  4'd15, 1'b1, 1'b0, 8'hF9,   1});
    vecs.push_back('{4'd2,  4'd12, 1'b1, 1'b0, 8'hF8,   3});
    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].sm, vecs[i].ct, 0, go, gl);
      check($sformatf("lit_o_%0d", i),   int'(go), int'(vecs[i].eo));
      check($sformatf("lit_lat_%0d", i), gl,       vecs[i].el);
    end

    // Backpressure: consumer stalls 5 cycles while new requests are offered
    run_op(4'd6, 4'd7, 1'b0, 1'b1, 5, go, gl);
    check("bp_o", int'(go), 42);
    check("bp_lat", gl, 4);

    // Asynchronous reset two edges into RUN discards the operation
    @(negedge clk);
    a = 4'd11; b = 4'd13; signed_mode = 1'b0; const_time = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_rst_o",         int'(o),         0);
    check("midrun_rst_out_valid", int'(out_valid), 0);
    check("midrun_rst_busy",      int'(busy),      0);
    check("midrun_rst_in_ready",  int'(in_ready),  1);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd9, 4'd9, 1'b0, 1'b1, 0, go, gl);
    check("after_rst_o", int'(go), 81);
    check("after_rst_lat", gl, 4);

    // Exhaustive constant-time sweep with the twin copy in lockstep
    @(negedge clk);
    twin_clr = 1'b1;
    @(negedge clk);
    twin_clr = 1'b0;
    twin_en  = 1'b1;
    for (int sm = 0; sm < 2; sm++) begin
      for (int i = 0; i < 256; i++) begin
        pair = 8'(i);
        run_op(pair[7:4], pair[3:0], 1'(sm), 1'b1, 0, go, gl);
        check("exh_lat", gl, W);
        check("exh_o", int'(go), int'(ref_prod(pair[7:4], pair[3:0], 1'(sm))));
      end
    end
    @(negedge clk);
    twin_en = 1'b0;

    // Random mix of modes and consumer stalls
    for (int k = 0; k < 300; k++) begin
      logic [W-1:0] rx, ry;
      logic         rs, rc;
      rx = W'($urandom); ry = W'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      run_op(rx, ry, rs, rc, int'($urandom_range(0, 3)), go, gl);
      check("rnd_lat", gl, ref_lat(rx, ry, rs, rc));
      check("rnd_o", int'(go), int'(ref_prod(rx, ry, rs)));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
